// File: rtl/pipe_memory.sv
// pipe_memory: M-to-W pipeline boundary of a 5-stage RV32 core.
// Holds the byte-addressed internal data RAM (little-endian). Stores commit
// at the M-stage edge, and loads return the RAM word one cycle later, in step
// with the W-stage registers. Load extension and the writeback result mux are
// formed from the registered W-stage state.
module pipe_memory #(
  parameter int DATA_WIDTH    = 32,
  parameter int WRITE_WIDTH   = 5,
  parameter int MEM_ADDR_BITS = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallm,
  input  logic                   flushw,
  input  logic                   regwritem,
  input  logic [1:0]             resultsrcm,
  input  logic                   memwritem,
  input  logic [2:0]             funct3m,
  input  logic [DATA_WIDTH-1:0]  aluresultm,
  input  logic [DATA_WIDTH-1:0]  writedatam,
  input  logic [WRITE_WIDTH-1:0] rdm,
  input  logic [DATA_WIDTH-1:0]  pcplus4m,
  output logic                   regwritew,
  output logic [WRITE_WIDTH-1:0] rdw,
  output logic [DATA_WIDTH-1:0]  resultw,
  output logic [DATA_WIDTH-1:0]  aluresultw,
  output logic [DATA_WIDTH-1:0]  readdataw
);

  // The RAM is organised as 32-bit words with four byte lanes.
  localparam int WORD_IDX_BITS = MEM_ADDR_BITS - 2;
  localparam int MEM_WORDS     = 1 << WORD_IDX_BITS;

  // Byte-lane write mask for a store. Only the size bits of funct3 matter
  // for stores. Misaligned low address bits are dropped, so the access is
  // aligned down. An undefined size writes nothing.
  function automatic logic [3:0] store_mask(input logic [1:0] size,
                                            input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      2'b00: begin
        case (lo)
          2'b00:   m = 4'b0001;
          2'b01:   m = 4'b0010;
          2'b10:   m = 4'b0100;
          2'b11:   m = 4'b1000;
          default: m = 4'b0000;
        endcase
      end
      2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Store data copied into every lane it may occupy. The mask then picks
  // the lanes that are actually written.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] wd);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      2'b10:   d = wd;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  // Select the byte or halfword lane from the fetched word, then sign- or
  // zero-extend it to DATA_WIDTH. An undefined load type returns zero.
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0]  f3,
                                                        input logic [1:0]  lo,
                                                        input logic [31:0] word);
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  r = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
      default: r = {DATA_WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Data RAM. It is deliberately left out of reset.
  logic [31:0] r_mem [0:MEM_WORDS-1];

  // W-stage registers.
  logic                   r_regwrite;
  logic [1:0]             r_resultsrc;
  logic [WRITE_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]  r_aluresult;
  logic [DATA_WIDTH-1:0]  r_pcplus4;
  logic [2:0]             r_funct3;
  logic [1:0]             r_addr_lo;
  logic [31:0]            r_rdword;

  // M-stage decode.
  logic [WORD_IDX_BITS-1:0] w_word_idx;
  logic [1:0]               w_addr_lo;
  logic                     w_wr_en;
  logic [3:0]               w_be;
  logic [31:0]              w_st_data;
  logic [31:0]              w_mem_word;
  logic [31:0]              w_rd_word;

  assign w_word_idx = aluresultm[MEM_ADDR_BITS-1:2];
  assign w_addr_lo  = aluresultm[1:0];
  // A store is blocked while the pipe is stalled or in reset.
  assign w_wr_en    = memwritem & ~stallm & ~rst;
  assign w_be       = store_mask(funct3m[1:0], w_addr_lo);
  assign w_st_data  = store_lanes(funct3m[1:0], writedatam);
  assign w_mem_word = r_mem[w_word_idx];

  // Write-first read path: the bytes being stored this cycle bypass the array.
  always_comb begin
    w_rd_word = w_mem_word;
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en && w_be[i]) begin
        w_rd_word[8*i +: 8] = w_st_data[8*i +: 8];
      end else begin
        w_rd_word[8*i +: 8] = w_mem_word[8*i +: 8];
      end
    end
  end

  // Commit the enabled byte lanes of a store into the RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_word_idx][8*i +: 8] <= w_st_data[8*i +: 8];
        end
      end
    end
  end

  // Update the W-stage registers. Priority: reset, then flush, then stall
  // (hold everything, including the read word), then a normal load.
  always_ff @(posedge clk) begin
    if (rst || flushw) begin
      r_regwrite  <= 1'b0;
      r_resultsrc <= 2'b00;
      r_rd        <= {WRITE_WIDTH{1'b0}};
      r_aluresult <= {DATA_WIDTH{1'b0}};
      r_pcplus4   <= {DATA_WIDTH{1'b0}};
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_rdword    <= 32'h0000_0000;
    end else if (!stallm) begin
      r_regwrite  <= regwritem;
      r_resultsrc <= resultsrcm;
      r_rd        <= rdm;
      r_aluresult <= aluresultm;
      r_pcplus4   <= pcplus4m;
      r_funct3    <= funct3m;
      r_addr_lo   <= w_addr_lo;
      r_rdword    <= w_rd_word;
    end
  end

  // Writeback result select, formed from the registered W-stage state.
  always_comb begin
    readdataw = load_extend(r_funct3, r_addr_lo, r_rdword);
    case (r_resultsrc)
      2'b00:   resultw = r_aluresult;
      2'b01:   resultw = readdataw;
      2'b10:   resultw = r_pcplus4;
      2'b11:   resultw = {DATA_WIDTH{1'b0}};
      default: resultw = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign regwritew  = r_regwrite;
  assign rdw        = r_rd;
  assign aluresultw = r_aluresult;

endmodule

// File: tb/tb_pipe_memory.sv
// Directed bench for pipe_memory with a queue-based scoreboard.
module tb_pipe_memory;

  logic        clk = 1'b0;
  logic        rst, stallm, flushw, regwritem, memwritem;
  logic [1:0]  resultsrcm;
  logic [2:0]  funct3m;
  logic [31:0] aluresultm, writedatam, pcplus4m;
  logic [4:0]  rdm;
  logic        regwritew;
  logic [4:0]  rdw;
  logic [31:0] resultw, aluresultw, readdataw;

  int checks   = 0;
  int failures = 0;
  string tag;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] res;
  } exp_t;

  exp_t sb_q[$];

  pipe_memory dut (
    .clk(clk), .rst(rst), .stallm(stallm), .flushw(flushw),
    .regwritem(regwritem), .resultsrcm(resultsrcm), .memwritem(memwritem),
    .funct3m(funct3m), .aluresultm(aluresultm), .writedatam(writedatam),
    .rdm(rdm), .pcplus4m(pcplus4m), .regwritew(regwritew), .rdw(rdw),
    .resultw(resultw), .aluresultw(aluresultw), .readdataw(readdataw)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic drv(input logic rw, input logic [1:0] rs, input logic mw,
                     input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [4:0] rd,
                     input logic [31:0] pc4);
    regwritem  = rw;
    resultsrcm = rs;
    memwritem  = mw;
    funct3m    = f3;
    aluresultm = addr;
    writedatam = wd;
    rdm        = rd;
    pcplus4m   = pc4;
  endtask

  task automatic expect_w(input logic rw, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] rdata,
                          input logic [31:0] res);
    exp_t e;
    e.rw = rw; e.rd = rd; e.alu = alu; e.rdata = rdata; e.res = res;
    sb_q.push_back(e);
  endtask

  // Clock once, then compare the W-stage outputs with the oldest expectation.
  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() > 0) else begin
      failures++;
      $error("FAIL %s scoreboard empty: observed size=%0d expected >0", tag, sb_q.size());
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      assert (regwritew === e.rw) else begin
        failures++;
        $error("FAIL %s regwritew observed=%0b expected=%0b", tag, regwritew, e.rw);
      end
      checks++;
      assert (rdw === e.rd) else begin
        failures++;
        $error("FAIL %s rdw observed=%0d expected=%0d", tag, rdw, e.rd);
      end
      checks++;
      assert (aluresultw === e.alu) else begin
        failures++;
        $error("FAIL %s aluresultw observed=%h expected=%h", tag, aluresultw, e.alu);
      end
      checks++;
      assert (readdataw === e.rdata) else begin
        failures++;
        $error("FAIL %s readdataw observed=%h expected=%h", tag, readdataw, e.rdata);
      end
      checks++;
      assert (resultw === e.res) else begin
        failures++;
        $error("FAIL %s resultw observed=%h expected=%h", tag, resultw, e.res);
      end
    end
  endtask

  initial begin
    rst = 1'b1; stallm = 1'b0; flushw = 1'b0;
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd9, 32'h44);

    // Reset state
    tag = "reset0";    expect_w(1'b0, 5'd0, 32'h0, 32'h0, 32'h0); tick_check();
    tag = "reset1";    expect_w(1'b0, 5'd0, 32'h0, 32'h0, 32'h0); tick_check();
    rst = 1'b0;

    // sw DEADBEEF @0x100; the write-first read path returns the new word
    drv(1'b0, 2'b00, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 5'd0, 32'h10);
    tag = "sw_100";    expect_w(1'b0, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'h100); tick_check();
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd5, 32'h14);
    tag = "lw_100";    expect_w(1'b1, 5'd5, 32'h100, 32'hDEAD_BEEF, 32'hDEAD_BEEF); tick_check();

    // Load extension variants
    drv(1'b1, 2'b01, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd6, 32'h18);
    tag = "lb_103";    expect_w(1'b1, 5'd6, 32'h103, 32'hFFFF_FFDE, 32'hFFFF_FFDE); tick_check();
    drv(1'b1, 2'b01, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd6, 32'h1C);
    tag = "lbu_103";   expect_w(1'b1, 5'd6, 32'h103, 32'h0000_00DE, 32'h0000_00DE); tick_check();
    drv(1'b1, 2'b01, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd6, 32'h20);
    tag = "lh_102";    expect_w(1'b1, 5'd6, 32'h102, 32'hFFFF_DEAD, 32'hFFFF_DEAD); tick_check();
    drv(1'b1, 2'b01, 1'b0, 3'b101, 32'h0000_0100, 32'h0, 5'd6, 32'h24);
    tag = "lhu_100";   expect_w(1'b1, 5'd6, 32'h100, 32'h0000_BEEF, 32'h0000_BEEF); tick_check();

    // sb 0x55 @0x101 (upper data bits must be ignored)
    drv(1'b0, 2'b00, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_5655, 5'd0, 32'h28);
    tag = "sb_101";    expect_w(1'b0, 5'd0, 32'h101, 32'h0000_0055, 32'h101); tick_check();
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd8, 32'h2C);
    tag = "lw_after_sb"; expect_w(1'b1, 5'd8, 32'h100, 32'hDEAD_55EF, 32'hDEAD_55EF); tick_check();

    // sh 0x1234 @0x103, aligned down to 0x102
    drv(1'b0, 2'b00, 1'b1, 3'b001, 32'h0000_0103, 32'hFFFF_1234, 5'd0, 32'h30);
    tag = "sh_103";    expect_w(1'b0, 5'd0, 32'h103, 32'h0000_1234, 32'h103); tick_check();
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd8, 32'h34);
    tag = "lw_after_sh"; expect_w(1'b1, 5'd8, 32'h100, 32'h1234_55EF, 32'h1234_55EF); tick_check();

    // Result mux: pcplus4 and the zero selection
    drv(1'b1, 2'b10, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd1, 32'h0000_2000);
    tag = "res_pc4";   expect_w(1'b1, 5'd1, 32'h100, 32'h1234_55EF, 32'h0000_2000); tick_check();
    drv(1'b1, 2'b11, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd2, 32'h0000_2004);
    tag = "res_zero";  expect_w(1'b1, 5'd2, 32'h100, 32'h1234_55EF, 32'h0); tick_check();

    // Stall: a store held for two cycles, then released
    drv(1'b0, 2'b00, 1'b1, 3'b010, 32'h0000_0200, 32'h1111_1111, 5'd0, 32'h40);
    tag = "sw_200";    expect_w(1'b0, 5'd0, 32'h200, 32'h1111_1111, 32'h200); tick_check();
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd3, 32'h44);
    tag = "lw_200";    expect_w(1'b1, 5'd3, 32'h200, 32'h1111_1111, 32'h1111_1111); tick_check();
    stallm = 1'b1;
    drv(1'b0, 2'b00, 1'b1, 3'b010, 32'h0000_0200, 32'hAAAA_AAAA, 5'd9, 32'h48);
    tag = "stall1";    expect_w(1'b1, 5'd3, 32'h200, 32'h1111_1111, 32'h1111_1111); tick_check();
    tag = "stall2";    expect_w(1'b1, 5'd3, 32'h200, 32'h1111_1111, 32'h1111_1111); tick_check();
    stallm = 1'b0;
    tag = "stall_rel"; expect_w(1'b0, 5'd9, 32'h200, 32'hAAAA_AAAA, 32'h200); tick_check();
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 5'd3, 32'h4C);
    tag = "lw_200b";   expect_w(1'b1, 5'd3, 32'h200, 32'hAAAA_AAAA, 32'hAAAA_AAAA); tick_check();

    // Stall must suppress the store: a store stalled, then dropped
    drv(1'b0, 2'b00, 1'b1, 3'b010, 32'h0000_0300, 32'h3333_3333, 5'd0, 32'h50);
    tag = "sw_300";    expect_w(1'b0, 5'd0, 32'h300, 32'h3333_3333, 32'h300); tick_check();
    stallm = 1'b1;
    drv(1'b0, 2'b00, 1'b1, 3'b010, 32'h0000_0300, 32'hCCCC_CCCC, 5'd0, 32'h54);
    tag = "stall_sw";  expect_w(1'b0, 5'd0, 32'h300, 32'h3333_3333, 32'h300); tick_check();
    stallm = 1'b0;
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4, 32'h58);
    tag = "lw_300";    expect_w(1'b1, 5'd4, 32'h300, 32'h3333_3333, 32'h3333_3333); tick_check();

    // Flush clears W but the concurrent store still lands
    flushw = 1'b1;
    drv(1'b1, 2'b01, 1'b1, 3'b010, 32'h0000_0400, 32'h7777_7777, 5'd7, 32'h5C);
    tag = "flush";     expect_w(1'b0, 5'd0, 32'h0, 32'h0, 32'h0); tick_check();
    flushw = 1'b0;
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd7, 32'h60);
    tag = "lw_400";    expect_w(1'b1, 5'd7, 32'h400, 32'h7777_7777, 32'h7777_7777); tick_check();

    // Flush has priority over stall
    flushw = 1'b1; stallm = 1'b1;
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd7, 32'h64);
    tag = "flush_stall"; expect_w(1'b0, 5'd0, 32'h0, 32'h0, 32'h0); tick_check();
    flushw = 1'b0; stallm = 1'b0;

    // Reset mid-stream suppresses a pending store
    drv(1'b0, 2'b00, 1'b1, 3'b010, 32'h0000_0500, 32'h5555_5555, 5'd0, 32'h68);
    tag = "sw_500";    expect_w(1'b0, 5'd0, 32'h500, 32'h5555_5555, 32'h500); tick_check();
    rst = 1'b1;
    drv(1'b1, 2'b01, 1'b1, 3'b010, 32'h0000_0500, 32'h9999_9999, 5'd4, 32'h6C);
    tag = "rst_store"; expect_w(1'b0, 5'd0, 32'h0, 32'h0, 32'h0); tick_check();
    rst = 1'b0;
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd4, 32'h70);
    tag = "lw_500";    expect_w(1'b1, 5'd4, 32'h500, 32'h5555_5555, 32'h5555_5555); tick_check();

    // Upper address bits are ignored: 0x20100 aliases 0x100
    drv(1'b1, 2'b01, 1'b0, 3'b010, 32'h0002_0100, 32'h0, 5'd2, 32'h74);
    tag = "alias_100"; expect_w(1'b1, 5'd2, 32'h0002_0100, 32'h1234_55EF, 32'h1234_55EF); tick_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
